// File: rtl/ddr_req_scheduler.sv
// ddr_req_scheduler: two request queues (read/write) feeding a DDR5 command FSM one command at
// a time. Same-row requests are chained into pipelined bursts (mc_ppl=1); the last request of a
// burst auto-precharges and the scheduler waits CLOSE_CYC cycles before arbitrating again.
// Optional feature macro: SCHED_STARVE_GUARD_EN (caps a burst at MAX_BURST grants when the other
// queue is waiting, then grants the other queue once regardless of WR_HWM).
module ddr_req_scheduler #(
    parameter int DEPTH     = 4,
    parameter int ROW_W     = 16,
    parameter int ID_W      = 4,
    parameter int WR_HWM    = 3,
    parameter int CLOSE_CYC = 12,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [ROW_W-1:0] rd_req_row,
    input  logic [ID_W-1:0]  rd_req_id,
    input  logic             wr_req_valid,
    output logic             wr_req_ready,
    input  logic [ROW_W-1:0] wr_req_row,
    input  logic [ID_W-1:0]  wr_req_id,
    input  logic             mc_ready,
    output logic             mc_rd_valid,
    output logic             mc_wr_valid,
    output logic             mc_ppl,
    output logic [ROW_W-1:0] mc_row,
    output logic [ID_W-1:0]  mc_id,
    output logic [1:0]       sched_state
);

`ifdef SCHED_STARVE_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int CLW = $clog2(CLOSE_CYC + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRdBurst = 2'b01,
        StWrBurst = 2'b10,
        StClose   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [CLW-1:0] close_q, close_d;
    logic [BW-1:0]  burst_q;
    logic           starve_q, starve_d;
    logic           starve_wr_q, starve_wr_d;
    logic           hold_q, ppl_hold_q;

    logic [ROW_W-1:0] rq_row [DEPTH];
    logic [ID_W-1:0]  rq_id  [DEPTH];
    logic [ROW_W-1:0] wq_row [DEPTH];
    logic [ID_W-1:0]  wq_id  [DEPTH];
    logic [PW-1:0]    rq_wp, rq_rp, wq_wp, wq_rp;
    logic [PW-1:0]    rq_rp_nx, wq_rp_nx;
    logic [CW-1:0]    rq_cnt, wq_cnt;

    logic rd_push, wr_push, rd_pop, wr_pop, xfer;
    logic rd_ne, wr_ne, rd_match, wr_match, cut, ppl_raw;

    assign rd_req_ready = (rq_cnt != CW'(DEPTH));
    assign wr_req_ready = (wq_cnt != CW'(DEPTH));
    assign rd_push      = rd_req_valid && rd_req_ready;
    assign wr_push      = wr_req_valid && wr_req_ready;

    assign mc_rd_valid = (state_q == StRdBurst);
    assign mc_wr_valid = (state_q == StWrBurst);
    assign xfer        = (mc_rd_valid || mc_wr_valid) && mc_ready;
    assign rd_pop      = xfer && mc_rd_valid;
    assign wr_pop      = xfer && mc_wr_valid;

    assign rd_ne    = (rq_cnt != '0);
    assign wr_ne    = (wq_cnt != '0);
    assign rq_rp_nx = rq_rp + 1'b1;
    assign wq_rp_nx = wq_rp + 1'b1;
    assign rd_match = (rq_cnt >= CW'(2)) && (rq_row[rq_rp_nx] == rq_row[rq_rp]);
    assign wr_match = (wq_cnt >= CW'(2)) && (wq_row[wq_rp_nx] == wq_row[wq_rp]);

    // >= rather than == so a burst that ran past the cap (other queue was empty) still cuts
    // as soon as the other queue fills; the counter saturates at MAX_BURST.
    assign cut = GuardEn && (burst_q >= BW'(MAX_BURST - 1)) &&
                 (mc_rd_valid ? wr_ne : rd_ne);

    // Present the head of the active queue; ppl is latched while stalled so it stays stable.
    always_comb begin
        ppl_raw = 1'b0;
        mc_ppl  = 1'b0;
        mc_row  = '0;
        mc_id   = '0;
        if (mc_rd_valid) begin
            ppl_raw = rd_match && !cut;
            mc_row  = rq_row[rq_rp];
            mc_id   = rq_id[rq_rp];
        end else if (mc_wr_valid) begin
            ppl_raw = wr_match && !cut;
            mc_row  = wq_row[wq_rp];
            mc_id   = wq_id[wq_rp];
        end
        if (mc_rd_valid || mc_wr_valid) begin
            mc_ppl = hold_q ? ppl_hold_q : ppl_raw;
        end
    end

    assign sched_state = state_q;

    // Queue storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            rq_row[rq_wp] <= rd_req_row;
            rq_id[rq_wp]  <= rd_req_id;
        end
        if (wr_push) begin
            wq_row[wq_wp] <= wr_req_row;
            wq_id[wq_wp]  <= wr_req_id;
        end
    end

    // Queue pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rq_wp  <= '0;
            rq_rp  <= '0;
            rq_cnt <= '0;
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (rd_push) rq_wp <= rq_wp + 1'b1;
            if (rd_pop)  rq_rp <= rq_rp_nx;
            if (wr_push) wq_wp <= wq_wp + 1'b1;
            if (wr_pop)  wq_rp <= wq_rp_nx;
            rq_cnt <= rq_cnt + CW'(rd_push) - CW'(rd_pop);
            wq_cnt <= wq_cnt + CW'(wr_push) - CW'(wr_pop);
        end
    end

    // FSM next state: arbitration in IDLE, burst chaining, close countdown.
    always_comb begin
        state_d     = state_q;
        close_d     = close_q;
        starve_d    = starve_q;
        starve_wr_d = starve_wr_q;
        case (state_q)
            StIdle: begin
                if (mc_ready) begin
                    if (rd_ne && wr_ne) begin
                        if (starve_q) begin
                            state_d = starve_wr_q ? StWrBurst : StRdBurst;
                        end else if (wq_cnt >= CW'(WR_HWM)) begin
                            state_d = StWrBurst;
                        end else begin
                            state_d = StRdBurst;
                        end
                    end else if (rd_ne) begin
                        state_d = StRdBurst;
                    end else if (wr_ne) begin
                        state_d = StWrBurst;
                    end
                    if (rd_ne || wr_ne) starve_d = 1'b0;
                end
            end
            StRdBurst, StWrBurst: begin
                if (xfer && !mc_ppl) begin
                    state_d = StClose;
                    close_d = CLW'(CLOSE_CYC - 1);
                    if (cut) begin
                        starve_d    = 1'b1;
                        starve_wr_d = (state_q == StRdBurst);
                    end
                end
            end
            default: begin
                if (close_q == '0) state_d = StIdle;
                else               close_d = close_q - 1'b1;
            end
        endcase
    end

    // FSM state, counters and ppl hold register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            close_q     <= '0;
            burst_q     <= '0;
            starve_q    <= 1'b0;
            starve_wr_q <= 1'b0;
            hold_q      <= 1'b0;
            ppl_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            close_q     <= close_d;
            starve_q    <= starve_d;
            starve_wr_q <= starve_wr_d;
            hold_q      <= (mc_rd_valid || mc_wr_valid) && !mc_ready;
            ppl_hold_q  <= mc_ppl;
            if (state_q == StIdle) begin
                burst_q <= '0;
            end else if (xfer && (burst_q != BW'(MAX_BURST))) begin
                burst_q <= burst_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_req_scheduler.sv
// Self-checking bench for ddr_req_scheduler. A monitor pops expected commands from a scoreboard
// queue on every transfer; scenario tasks push expectations and check state/timing inline.
module tb_ddr_req_scheduler;

    localparam logic [1:0] SIdle = 2'b00;
    localparam logic [1:0] SRd   = 2'b01;
    localparam logic [1:0] SWr   = 2'b10;
    localparam logic [1:0] SCl   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req_valid = 1'b0, wr_req_valid = 1'b0;
    logic        rd_req_ready, wr_req_ready;
    logic [15:0] rd_req_row = '0, wr_req_row = '0;
    logic [3:0]  rd_req_id = '0, wr_req_id = '0;
    logic        mc_ready = 1'b0;
    logic        mc_rd_valid, mc_wr_valid, mc_ppl;
    logic [15:0] mc_row;
    logic [3:0]  mc_id;
    logic [1:0]  sched_state;

    typedef struct packed {
        logic        wr;
        logic [15:0] row;
        logic [3:0]  id;
        logic        ppl;
    } cmd_t;

    cmd_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic  prev_stall = 1'b0;
    logic [22:0] prev_out = '0;

    ddr_req_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_row   (rd_req_row),
        .rd_req_id    (rd_req_id),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_row   (wr_req_row),
        .wr_req_id    (wr_req_id),
        .mc_ready     (mc_ready),
        .mc_rd_valid  (mc_rd_valid),
        .mc_wr_valid  (mc_wr_valid),
        .mc_ppl       (mc_ppl),
        .mc_row       (mc_row),
        .mc_id        (mc_id),
        .sched_state  (sched_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: scoreboard compare on each transfer, plus handshake-stability rules.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (mc_rd_valid && mc_wr_valid) begin
                checks++; errors++;
                $display("FAIL both_valid: rd and wr valid both 1 at %0t", $time);
            end
            if (prev_stall) begin
                checks++;
                if ({mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_stable: got %h required %h", 
                             {mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id}, prev_out);
                end
            end
            if ((mc_rd_valid || mc_wr_valid) && mc_ready) begin
                cmd_t got, want;
                got = '{wr: mc_wr_valid, row: mc_row, id: mc_id, ppl: mc_ppl};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd: got wr=%0b row=%h id=%0d ppl=%0b, none expected",
                             got.wr, got.row, got.id, got.ppl);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL cmd: got wr=%0b row=%h id=%0d ppl=%0b required wr=%0b row=%h id=%0d ppl=%0b",
                                 got.wr, got.row, got.id, got.ppl,
                                 want.wr, want.row, want.id, want.ppl);
                    end
                end
            end
            prev_stall <= (mc_rd_valid || mc_wr_valid) && !mc_ready;
            prev_out   <= {mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic wr, input logic [15:0] row, input logic [3:0] id,
                              input logic ppl);
        exp_q.push_back('{wr: wr, row: row, id: id, ppl: ppl});
    endtask

    task automatic push_rd(input logic [15:0] row, input logic [3:0] id);
        int n = 0;
        while (!rd_req_ready && n < 200) begin step(); n++; end
        if (!rd_req_ready) begin
            checks++; errors++;
            $display("FAIL push_rd_timeout: rd_req_ready=0 required 1");
        end
        rd_req_valid = 1'b1; rd_req_row = row; rd_req_id = id;
        step();
        rd_req_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [15:0] row, input logic [3:0] id);
        int n = 0;
        while (!wr_req_ready && n < 200) begin step(); n++; end
        if (!wr_req_ready) begin
            checks++; errors++;
            $display("FAIL push_wr_timeout: wr_req_ready=0 required 1");
        end
        wr_req_valid = 1'b1; wr_req_row = row; wr_req_id = id;
        step();
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int n = 0;
        while (sched_state !== st && n < budget) begin step(); n++; end
        checks++;
        if (sched_state !== st) begin
            errors++;
            $display("FAIL %s: sched_state=%b required %b", name, sched_state, st);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && sched_state == SIdle) && n < budget) begin step(); n++; end
        checks++;
        if (exp_q.size() != 0 || sched_state !== SIdle) begin
            errors++;
            $display("FAIL %s: %0d commands outstanding, state=%b required 0 and %b",
                     name, exp_q.size(), sched_state, SIdle);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        checks++;
        if ({sched_state, mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id, rd_req_ready,
             wr_req_ready} !== {SIdle, 3'b000, 16'h0, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL reset_state: st=%b rv=%b wv=%b ppl=%b row=%h id=%h rr=%b wr=%b required idle/zeros/ready",
                     sched_state, mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id,
                     rd_req_ready, wr_req_ready);
        end
    endtask

    task automatic test_single_read();
        int closes = 0;
        mc_ready = 1'b1;
        expect_cmd(1'b0, 16'h0012, 4'd5, 1'b0);
        push_rd(16'h0012, 4'd5);
        checks++;
        if (sched_state !== SIdle || mc_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: state=%b rv=%b required %b 0", sched_state, mc_rd_valid, SIdle);
        end
        step();
        checks++;
        if ({mc_rd_valid, mc_ppl, mc_row} !== {1'b1, 1'b0, 16'h0012}) begin
            errors++;
            $display("FAIL single_present: rv=%b ppl=%b row=%h required 1 0 0012",
                     mc_rd_valid, mc_ppl, mc_row);
        end
        step();
        for (int i = 0; i < 12; i++) begin
            if (sched_state == SCl) closes++;
            step();
        end
        checks++;
        if (closes != 12 || sched_state !== SIdle) begin
            errors++;
            $display("FAIL single_close: close cycles=%0d state after=%b required 12 and %b",
                     closes, sched_state, SIdle);
        end
        wait_drain(20, "single_drain");
    endtask

    task automatic test_burst();
        bit early_close = 0;
        mc_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            expect_cmd(1'b0, 16'h0040, 4'(i), (i != 3));
            push_rd(16'h0040, 4'(i));
        end
        mc_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            step();
            if (sched_state == SCl && exp_q.size() != 0) early_close = 1;
        end
        checks++;
        if (early_close) begin
            errors++;
            $display("FAIL burst_no_close: CLOSE seen between grants, required none");
        end
        wait_drain(40, "burst_drain");
    endtask

    task automatic test_arbitration();
        mc_ready = 1'b0;
        push_rd(16'h0100, 4'd1);
        push_wr(16'h0200, 4'd2);
        expect_cmd(1'b0, 16'h0100, 4'd1, 1'b0);
        expect_cmd(1'b1, 16'h0200, 4'd2, 1'b0);
        mc_ready = 1'b1;
        wait_drain(100, "arb_low_drain");
        mc_ready = 1'b0;
        push_wr(16'h0300, 4'd3);
        push_wr(16'h0301, 4'd4);
        push_wr(16'h0302, 4'd5);
        push_rd(16'h0400, 4'd6);
        expect_cmd(1'b1, 16'h0300, 4'd3, 1'b0);
        expect_cmd(1'b0, 16'h0400, 4'd6, 1'b0);
        expect_cmd(1'b1, 16'h0301, 4'd4, 1'b0);
        expect_cmd(1'b1, 16'h0302, 4'd5, 1'b0);
        mc_ready = 1'b1;
        wait_drain(200, "arb_hwm_drain");
    endtask

    task automatic test_full_and_wrap();
        int n = 0;
        mc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_cmd(1'b1, 16'h0500 + 16'(i), 4'(i), 1'b0);
            push_wr(16'h0500 + 16'(i), 4'(i));
        end
        checks++;
        if (wr_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: wr_req_ready=%b required 0", wr_req_ready);
        end
        // Offer while full; must be dropped (scoreboard would flag it otherwise).
        wr_req_valid = 1'b1; wr_req_row = 16'h05FF; wr_req_id = 4'hF;
        step();
        wr_req_valid = 1'b0;
        mc_ready = 1'b1;
        while (exp_q.size() == 4 && n < 20) begin step(); n++; end
        checks++;
        if (wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_pop: wr_req_ready=%b required 1", wr_req_ready);
        end
        wait_drain(200, "full_drain");
        for (int i = 0; i < 10; i++) begin
            expect_cmd(1'b1, 16'h0600 + 16'(i), 4'(i), 1'b0);
            push_wr(16'h0600 + 16'(i), 4'(i));
        end
        wait_drain(400, "wrap_drain");
    endtask

    task automatic test_stall();
        bit bad = 0;
        mc_ready = 1'b1;
        expect_cmd(1'b1, 16'h0700, 4'd9, 1'b0);
        push_wr(16'h0700, 4'd9);
        wait_state(SWr, 10, "stall_enter");
        mc_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if ({mc_wr_valid, mc_row, mc_id} !== {1'b1, 16'h0700, 4'd9}) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: wv=%b row=%h id=%0d required 1 0700 9",
                     mc_wr_valid, mc_row, mc_id);
        end
        mc_ready = 1'b1;
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_release: %0d outstanding after first ready cycle required 0",
                     exp_q.size());
        end
        wait_drain(40, "stall_drain");
    endtask

    task automatic test_guard();
        mc_ready = 1'b0;
        push_wr(16'h0900, 4'hA);
        for (int i = 0; i < 4; i++) push_rd(16'h0800, 4'(i));
`ifdef SCHED_STARVE_GUARD_EN
        for (int i = 0; i < 8; i++) expect_cmd(1'b0, 16'h0800, 4'(i), (i != 7));
        expect_cmd(1'b1, 16'h0900, 4'hA, 1'b0);
        expect_cmd(1'b0, 16'h0800, 4'd8, 1'b1);
        expect_cmd(1'b0, 16'h0800, 4'd9, 1'b0);
`else
        for (int i = 0; i < 10; i++) expect_cmd(1'b0, 16'h0800, 4'(i), (i != 9));
        expect_cmd(1'b1, 16'h0900, 4'hA, 1'b0);
`endif
        mc_ready = 1'b1;
        for (int i = 4; i < 10; i++) push_rd(16'h0800, 4'(i));
        wait_drain(300, "guard_drain");
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        mc_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_rd(16'h0077, 4'(i));
        expect_cmd(1'b0, 16'h0077, 4'd0, 1'b1);
        mc_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin step(); n++; end
        mc_ready = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if ({sched_state, mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id, rd_req_ready,
             wr_req_ready} !== {SIdle, 3'b000, 16'h0, 4'h0, 2'b11}) begin
            errors++;
            $display("FAIL mid_reset: st=%b rv=%b wv=%b ppl=%b row=%h id=%h rr=%b wr=%b required idle/zeros/ready",
                     sched_state, mc_rd_valid, mc_wr_valid, mc_ppl, mc_row, mc_id,
                     rd_req_ready, wr_req_ready);
        end
        rst = 1'b1;
        exp_q.delete();
        mc_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (sched_state !== SIdle || mc_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dropped: state=%b rv=%b required %b 0",
                     sched_state, mc_rd_valid, SIdle);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst();
        test_arbitration();
        test_full_and_wrap();
        test_stall();
        test_guard();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
